// File: rtl/coef_mem_sched.sv
// coef_mem_sched
// Schedules single-cycle accesses to a four-bank coefficient memory. There are
// two requesters: a host port for single-word reads and writes, and an engine
// that streams read bursts in address order. The two share one issue slot per
// cycle. In a burst, host and engine alternate whenever both want the slot.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   host_req/we/addr/wdata host single-word request, held until host_gnt
//   host_gnt              combinational grant, access issued this cycle
//   host_rdata/rvalid     host read data and its one-cycle strobe
//   eng_start/base/len    burst start pulse, start address, word count (0 = 2^LEN_WIDTH)
//   eng_busy              burst in progress (BURST or DRAIN)
//   eng_rdata/rvalid      burst read data, one strobe per word
//   eng_done              one-cycle pulse in DRAIN, alongside the last eng_rvalid
//   mem_addr/cen_sel/wen/wdata  issue bus to the bank controller (wen active-low)
//   mem_rdata             bank read data, valid the cycle after a read issue
module coef_mem_sched #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_gnt,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  host_rvalid,
  input  logic                  eng_start,
  input  logic [ADDR_WIDTH-1:0] eng_base,
  input  logic [LEN_WIDTH-1:0]  eng_len,
  output logic                  eng_busy,
  output logic [DATA_WIDTH-1:0] eng_rdata,
  output logic                  eng_rvalid,
  output logic                  eng_done,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_cen_sel,
  output logic                  mem_wen,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_DRAIN} state_t;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_HRD  = 2'd1;
  localparam logic [1:0] OWN_ENG  = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LEN_WIDTH:0]    REM_ONE  = {{LEN_WIDTH{1'b0}}, 1'b1};
  localparam logic [LEN_WIDTH:0]    REM_MAX  = {1'b1, {LEN_WIDTH{1'b0}}};

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] burst_addr;
  logic [ADDR_WIDTH-1:0] addr_q;
  // One bit wider than eng_len so that a length of 0 can hold 2^LEN_WIDTH.
  logic [LEN_WIDTH:0]    remaining;
  logic                  last_eng;
  logic [1:0]            own_p1;
  logic                  host_sel, eng_sel, issue;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (eng_start) state_nxt = S_BURST;
      S_BURST: if (eng_sel && (remaining == REM_ONE)) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Slot arbitration. Gating with rst_n keeps the combinational grant
  // quiet while reset is held. The host wins a burst slot only after an
  // engine slot, so each side gets at least every other cycle.
  always_comb begin
    host_sel = 1'b0;
    eng_sel  = 1'b0;
    if (rst_n) begin
      case (state)
        S_IDLE, S_DRAIN: host_sel = host_req;
        S_BURST: begin
          host_sel = host_req && last_eng;
          eng_sel  = !(host_req && last_eng);
        end
        default: ;
      endcase
    end
  end

  assign issue       = host_sel | eng_sel;
  assign host_gnt    = host_sel;
  assign mem_cen_sel = issue;
  assign mem_wen     = ~(host_sel & host_we);
  assign mem_wdata   = host_wdata;
  assign mem_addr    = eng_sel  ? burst_addr :
                       host_sel ? host_addr  : addr_q;

  assign eng_busy    = (state != S_IDLE);
  assign eng_done    = (state == S_DRAIN);

  // Burst counters: loaded only from IDLE, so a start pulse mid-burst is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_addr <= '0;
      remaining  <= '0;
    end else if ((state == S_IDLE) && eng_start) begin
      burst_addr <= eng_base;
      remaining  <= (eng_len == '0) ? REM_MAX : {1'b0, eng_len};
    end else if (eng_sel) begin
      burst_addr <= burst_addr + ADDR_ONE;
      remaining  <= remaining - REM_ONE;
    end
  end

  // Issue stage -> return stage: the owner tag steers next-cycle read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_eng <= 1'b0;
      own_p1   <= OWN_NONE;
      addr_q   <= '0;
    end else begin
      last_eng <= eng_sel;
      own_p1   <= eng_sel                 ? OWN_ENG :
                  (host_sel && !host_we)  ? OWN_HRD : OWN_NONE;
      if (issue) addr_q <= mem_addr;
    end
  end

  assign host_rvalid = (own_p1 == OWN_HRD);
  assign eng_rvalid  = (own_p1 == OWN_ENG);
  assign host_rdata  = mem_rdata;
  assign eng_rdata   = mem_rdata;

endmodule

// File: tb/tb_coef_mem_sched.sv
module tb_coef_mem_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        host_req, host_we;
  logic [13:0] host_addr;
  logic [31:0] host_wdata;
  logic        host_gnt;
  logic [31:0] host_rdata;
  logic        host_rvalid;
  logic        eng_start;
  logic [13:0] eng_base;
  logic [7:0]  eng_len;
  logic        eng_busy;
  logic [31:0] eng_rdata;
  logic        eng_rvalid, eng_done;
  logic [13:0] mem_addr;
  logic        mem_cen_sel, mem_wen;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  int n_chk = 0;
  int n_pass = 0;

  // results of the last run_burst
  logic [13:0] iss_q[$];
  int n_erv, n_hgnt, n_hrv, data_err, hrv_err, max_wait, done_cyc, last_iss;

  always #5 clk = ~clk;

  coef_mem_sched dut (
    .clk(clk), .rst_n(rst_n),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt),
    .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .eng_start(eng_start), .eng_base(eng_base), .eng_len(eng_len),
    .eng_busy(eng_busy), .eng_rdata(eng_rdata), .eng_rvalid(eng_rvalid),
    .eng_done(eng_done),
    .mem_addr(mem_addr), .mem_cen_sel(mem_cen_sel), .mem_wen(mem_wen),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory content pattern: every word holds its own address tagged with A5A5.
  function automatic logic [31:0] pat(input logic [13:0] a);
    return 32'hA5A5_0000 | {18'h0, a};
  endfunction

  // Bank model: read data appears the cycle after a read issue.
  always @(posedge clk)
    if (mem_cen_sel && mem_wen) mem_rdata <= pat(mem_addr);

  function automatic logic [31:0] qa(input int i);
    if (i < iss_q.size()) return {18'h0, iss_q[i]};
    return 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Start a burst from IDLE and watch it to eng_done (or budget exhaustion).
  // hreq keeps a host read of 0x2000 pending throughout; ign_at pulses a
  // stray eng_start on that burst cycle.
  task automatic run_burst(input logic [13:0] base, input logic [7:0] len,
                           input bit hreq, input int ign_at, input int budget);
    int k, wt;
    iss_q.delete();
    n_erv = 0; n_hgnt = 0; n_hrv = 0; data_err = 0; hrv_err = 0;
    max_wait = 0; done_cyc = -1; last_iss = -1; k = 0; wt = 0;
    @(posedge clk); #1;
    eng_start = 1'b1; eng_base = base; eng_len = len;
    host_req = hreq; host_we = 1'b0; host_addr = 14'h2000;
    @(negedge clk);
    if (host_gnt) n_hgnt++;
    forever begin
      @(posedge clk); #1;
      eng_start = (k == ign_at);
      if (k == ign_at) begin eng_base = 14'h3000; eng_len = 8'd1; end
      @(negedge clk);
      k++;
      if (mem_cen_sel && !host_gnt) begin iss_q.push_back(mem_addr); last_iss = k; end
      if (host_gnt) n_hgnt++;
      if (host_req && !host_gnt) wt++; else wt = 0;
      if (wt > max_wait) max_wait = wt;
      if (eng_rvalid) begin
        if (eng_rdata !== pat(qa(n_erv)[13:0]) || n_erv >= iss_q.size()) data_err++;
        n_erv++;
      end
      if (host_rvalid) begin
        n_hrv++;
        if (host_rdata !== pat(14'h2000)) hrv_err++;
      end
      if (eng_done) begin done_cyc = k; break; end
      if (k >= budget) break;
    end
    eng_start = 1'b0;
    host_req  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; host_req = 1'b1; host_we = 1'b0; host_addr = 14'h0;
    host_wdata = 32'h0; eng_start = 1'b0; eng_base = 14'h0; eng_len = 8'h0;
    #3;
    chk("rst_gnt", {31'h0, host_gnt}, 32'h0);
    chk("rst_cen", {31'h0, mem_cen_sel}, 32'h0);
    chk("rst_wen", {31'h0, mem_wen}, 32'h1);
    chk("rst_busy", {31'h0, eng_busy}, 32'h0);
    chk("rst_addr", {18'h0, mem_addr}, 32'h0);
    host_req = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // host read in IDLE
    @(posedge clk); #1;
    host_req = 1'b1; host_we = 1'b0; host_addr = 14'h0123;
    @(negedge clk);
    chk("hrd_gnt", {31'h0, host_gnt}, 32'h1);
    chk("hrd_addr", {18'h0, mem_addr}, 32'h0123);
    chk("hrd_wen", {31'h0, mem_wen}, 32'h1);
    @(posedge clk); #1; host_req = 1'b0;
    @(negedge clk);
    chk("hrd_rvalid", {31'h0, host_rvalid}, 32'h1);
    chk("hrd_data", host_rdata, 32'hA5A5_0123);
    chk("hrd_ervalid", {31'h0, eng_rvalid}, 32'h0);
    chk("idle_cen", {31'h0, mem_cen_sel}, 32'h0);
    chk("idle_addr_hold", {18'h0, mem_addr}, 32'h0123);

    // host write in IDLE
    @(posedge clk); #1;
    host_req = 1'b1; host_we = 1'b1; host_addr = 14'h0055; host_wdata = 32'h1234_5678;
    @(negedge clk);
    chk("hwr_gnt", {31'h0, host_gnt}, 32'h1);
    chk("hwr_wen", {31'h0, mem_wen}, 32'h0);
    chk("hwr_wdata", mem_wdata, 32'h1234_5678);
    @(posedge clk); #1; host_req = 1'b0; host_we = 1'b0;
    @(negedge clk);
    chk("hwr_no_rvalid", {31'h0, host_rvalid}, 32'h0);
    chk("hwr_wen_rel", {31'h0, mem_wen}, 32'h1);
    chk("hwr_addr_hold", {18'h0, mem_addr}, 32'h0055);

    // plain burst across a bank boundary
    run_burst(14'h0FFE, 8'd4, 1'b0, -1, 50);
    chk("b4_count", iss_q.size(), 4);
    chk("b4_a0", qa(0), 32'h0FFE);
    chk("b4_a1", qa(1), 32'h0FFF);
    chk("b4_a2", qa(2), 32'h1000);
    chk("b4_a3", qa(3), 32'h1001);
    chk("b4_consec", last_iss, 4);
    chk("b4_rvalid", n_erv, 4);
    chk("b4_data", data_err, 0);
    chk("b4_done_lat", done_cyc - last_iss, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("b4_busy_end", {31'h0, eng_busy}, 32'h0);
    chk("b4_done_pulse", {31'h0, eng_done}, 32'h0);

    // address wrap
    run_burst(14'h3FFF, 8'd2, 1'b0, -1, 50);
    chk("wrap_count", iss_q.size(), 2);
    chk("wrap_a0", qa(0), 32'h3FFF);
    chk("wrap_a1", qa(1), 32'h0000);

    // contention with a permanently pending host read
    run_burst(14'h0010, 8'd6, 1'b1, -1, 60);
    chk("cont_count", iss_q.size(), 6);
    chk("cont_a5", qa(5), 32'h0015);
    chk("cont_done", done_cyc, 12);
    chk("cont_hgnt", n_hgnt, 7);
    chk("cont_hrv", n_hrv, 6);
    chk("cont_hdata", hrv_err, 0);
    chk("cont_wait", {31'h0, max_wait <= 1}, 32'h1);
    chk("cont_edata", data_err, 0);
    chk("cont_erv", n_erv, 6);

    // length 0 = 256 words
    run_burst(14'h0400, 8'd0, 1'b0, -1, 400);
    chk("l0_count", iss_q.size(), 256);
    chk("l0_rvalid", n_erv, 256);
    chk("l0_last", qa(255), 32'h04FF);
    chk("l0_done", done_cyc, 257);
    chk("l0_data", data_err, 0);

    // stray eng_start during BURST
    run_burst(14'h0100, 8'd4, 1'b0, 1, 50);
    chk("ign_count", iss_q.size(), 4);
    chk("ign_a3", qa(3), 32'h0103);
    chk("ign_done", done_cyc, 5);

    // reset with an engine read in flight
    @(posedge clk); #1;
    eng_start = 1'b1; eng_base = 14'h0200; eng_len = 8'd8;
    @(posedge clk); #1; eng_start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0; host_req = 1'b1;
    #1;
    chk("mrst_busy", {31'h0, eng_busy}, 32'h0);
    chk("mrst_ervalid", {31'h0, eng_rvalid}, 32'h0);
    chk("mrst_cen", {31'h0, mem_cen_sel}, 32'h0);
    chk("mrst_addr", {18'h0, mem_addr}, 32'h0);
    chk("mrst_gnt", {31'h0, host_gnt}, 32'h0);
    chk("mrst_wen", {31'h0, mem_wen}, 32'h1);
    chk("mrst_done", {31'h0, eng_done}, 32'h0);
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1; host_req = 1'b0;
    run_burst(14'h0300, 8'd3, 1'b0, -1, 50);
    chk("post_count", iss_q.size(), 3);
    chk("post_a0", qa(0), 32'h0300);
    chk("post_a2", qa(2), 32'h0302);
    chk("post_rvalid", n_erv, 3);
    chk("post_done", done_cyc, 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
